// File: rtl/cic_comb_decimator.sv
// cic_comb_decimator: decimating comb back end of a CIC filter.
// Downsamples the integrator chain output by DECIM and runs N_STAGES combs.
module cic_comb_decimator #(
    parameter int WIDTH      = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int N_STAGES   = 3,
    parameter int DECIM      = 8,
    parameter int DIFF_DELAY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data
);

    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0]       cnt;
    logic                capture;

    logic                dec_valid;
    logic [WIDTH-1:0]    dec_data;

    // Stage k input (sx/sv) and stage k result/valid (res/vld), k = 0..N-1
    logic [WIDTH-1:0]    sx  [N_STAGES];
    logic [N_STAGES-1:0] sv;
    logic [WIDTH-1:0]    res [N_STAGES];
    logic [N_STAGES-1:0] vld;
    logic [WIDTH-1:0]    dly [N_STAGES][DIFF_DELAY];

    // A sample is kept when it is the last valid one of a decimation frame
    assign capture = in_valid && (cnt == CNT_LAST);

    // Decimation counter advances on valid input only and wraps at DECIM-1
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (in_valid) begin
            cnt <= capture ? '0 : cnt + CNT_ONE;
        end
    end

    // Decimated register plus its one-cycle valid flag
    always_ff @(posedge clk) begin
        if (reset) begin
            dec_valid <= 1'b0;
            dec_data  <= '0;
        end else begin
            dec_valid <= capture;
            if (capture) begin
                dec_data <= in_data;
            end
        end
    end

    // Chain each comb stage onto the result of the one before it
    always_comb begin
        sx[0] = dec_data;
        sv[0] = dec_valid;
        for (int k = 1; k < N_STAGES; k++) begin
            sx[k] = res[k-1];
            sv[k] = vld[k-1];
        end
    end

    // Comb stages: y = x - x delayed by DIFF_DELAY, modular, hold when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int k = 0; k < N_STAGES; k++) begin
                res[k] <= '0;
                for (int j = 0; j < DIFF_DELAY; j++) begin
                    dly[k][j] <= '0;
                end
            end
        end else begin
            vld <= sv;
            for (int k = 0; k < N_STAGES; k++) begin
                if (sv[k]) begin
                    res[k]    <= sx[k] - dly[k][DIFF_DELAY-1];
                    dly[k][0] <= sx[k];
                    for (int j = 1; j < DIFF_DELAY; j++) begin
                        dly[k][j] <= dly[k][j-1];
                    end
                end
            end
        end
    end

    assign out_valid = vld[N_STAGES-1];
    assign out_data  = res[N_STAGES-1][WIDTH-1 -: OUT_WIDTH];

    // Low result bits below the output slice are intentionally dropped
    if (OUT_WIDTH < WIDTH) begin : g_trunc
        logic unused_low;
        assign unused_low = ^res[N_STAGES-1][WIDTH-OUT_WIDTH-1:0];
    end

endmodule

// File: tb/tb_cic_comb_decimator.sv
// tb_cic_comb_decimator: randomized and directed checks of the comb decimator.
// Expected streams come from a queue-based decimate-then-difference model.
module tb_cic_comb_decimator;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        iv [5];
    logic [15:0] id [5];
    logic        ov [5];
    logic [15:0] od [4];
    logic [7:0]  od_tr;

    int sel = 0;
    logic [15:0] stim_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] got_d[$];
    int          in_t[$];
    int          got_t[$];

    int n_cmp = 0;
    int n_err = 0;

    logic        mon_v;
    logic [15:0] mon_d;

    cic_comb_decimator #(.WIDTH(16), .OUT_WIDTH(16), .N_STAGES(3),
                         .DECIM(4), .DIFF_DELAY(1)) u_main (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_data(od[0]));

    cic_comb_decimator u_def (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_data(od[1]));

    cic_comb_decimator #(.WIDTH(16), .OUT_WIDTH(16), .N_STAGES(1),
                         .DECIM(1), .DIFF_DELAY(1)) u_wrap (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_data(id[2]),
        .out_valid(ov[2]), .out_data(od[2]));

    cic_comb_decimator #(.WIDTH(16), .OUT_WIDTH(16), .N_STAGES(1),
                         .DECIM(1), .DIFF_DELAY(2)) u_m2 (
        .clk(clk), .reset(reset), .in_valid(iv[3]), .in_data(id[3]),
        .out_valid(ov[3]), .out_data(od[3]));

    cic_comb_decimator #(.WIDTH(16), .OUT_WIDTH(8), .N_STAGES(1),
                         .DECIM(1), .DIFF_DELAY(1)) u_tr (
        .clk(clk), .reset(reset), .in_valid(iv[4]), .in_data(id[4]),
        .out_valid(ov[4]), .out_data(od_tr));

    // Record every output strobe of the selected instance with its cycle
    always @(negedge clk) begin
        case (sel)
            0: begin mon_v = ov[0]; mon_d = od[0]; end
            1: begin mon_v = ov[1]; mon_d = od[1]; end
            2: begin mon_v = ov[2]; mon_d = od[2]; end
            3: begin mon_v = ov[3]; mon_d = od[3]; end
            default: begin mon_v = ov[4]; mon_d = {8'h00, od_tr}; end
        endcase
        if (mon_v) begin
            got_d.push_back(mon_d);
            got_t.push_back(cyc);
        end
    end

    task automatic drive(input logic v, input logic [15:0] d);
        @(posedge clk);
        #1;
        iv[sel] = v;
        id[sel] = d;
        if (v) begin
            stim_q.push_back(d);
            in_t.push_back(cyc);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
            iv[sel] = 1'b0;
            id[sel] = 16'($urandom);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) iv[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        stim_q = {};
        in_t = {};
        got_d = {};
        got_t = {};
    endtask

    // Decimate: keep every d-th valid sample; then n passes of x[i]-x[i-m]
    task automatic model(input int n, input int d, input int m);
        logic [15:0] x[$];
        logic [15:0] y[$];
        logic [15:0] p;
        x = {};
        for (int i = 0; i < stim_q.size(); i++)
            if ((i + 1) % d == 0) x.push_back(stim_q[i]);
        for (int s = 0; s < n; s++) begin
            y = {};
            for (int i = 0; i < x.size(); i++) begin
                p = (i >= m) ? x[i-m] : 16'h0000;
                y.push_back(x[i] - p);
            end
            x = y;
        end
        exp_q = x;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (ov[i] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_valid[%0d] got %b want 0", i, ov[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (od[i] !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_data[%0d] got %h want 0000", i, od[i]);
            end
        end
        n_cmp++;
        if (od_tr !== 8'h00) begin
            n_err++;
            $display("FAIL reset_data_tr got %h want 00", od_tr);
        end
        // valid input while reset is held must not be captured
        sel = 2;
        @(posedge clk);
        #1;
        iv[2] = 1'b1;
        id[2] = 16'h1111;
        @(posedge clk);
        #1;
        reset = 1'b0;
        iv[2] = 1'b0;
        got_d = {};
        got_t = {};
        idle(5);
        n_cmp++;
        if (got_d.size() != 0) begin
            n_err++;
            $display("FAIL reset_priority got %0d outputs want 0", got_d.size());
        end
    endtask

    task automatic test_constant();
        sel = 0;
        do_reset();
        for (int n = 0; n < 16; n++) drive(1'b1, 16'd100);
        idle(8);
        model(3, 4, 1);
        n_cmp++;
        if (got_d.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL const_count got %0d want %0d", got_d.size(), exp_q.size());
        end
        for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL const_data[%0d] got %0d want %0d", i,
                         $signed(got_d[i]), $signed(exp_q[i]));
            end
        end
        if (got_t.size() > 0) begin
            n_cmp++;
            if (got_t[0] != in_t[3] + 4) begin
                n_err++;
                $display("FAIL const_latency got %0d want %0d", got_t[0], in_t[3] + 4);
            end
        end
        for (int i = 1; i < got_t.size(); i++) begin
            n_cmp++;
            if (got_t[i] - got_t[i-1] != 4) begin
                n_err++;
                $display("FAIL const_spacing[%0d] got %0d want 4", i, got_t[i] - got_t[i-1]);
            end
        end
    endtask

    task automatic test_ramp(input logic gapped);
        logic [15:0] ref_q[5];
        int gap;
        ref_q = '{16'd3, 16'hFFFE, 16'hFFFF, 16'd0, 16'd0};
        gap = gapped ? 8 : 4;
        sel = 0;
        do_reset();
        for (int n = 0; n < 20; n++) begin
            drive(1'b1, 16'(n));
            if (gapped) drive(1'b0, 16'($urandom));
        end
        idle(10);
        n_cmp++;
        if (got_d.size() != 5) begin
            n_err++;
            $display("FAIL ramp_count gap=%0d got %0d want 5", gapped, got_d.size());
        end
        for (int i = 0; i < got_d.size() && i < 5; i++) begin
            n_cmp++;
            if (got_d[i] !== ref_q[i]) begin
                n_err++;
                $display("FAIL ramp_data[%0d] gap=%0d got %0d want %0d", i, gapped,
                         $signed(got_d[i]), $signed(ref_q[i]));
            end
        end
        if (got_t.size() > 0) begin
            n_cmp++;
            if (got_t[0] != in_t[3] + 4) begin
                n_err++;
                $display("FAIL ramp_latency gap=%0d got %0d want %0d", gapped,
                         got_t[0], in_t[3] + 4);
            end
        end
        for (int i = 1; i < got_t.size(); i++) begin
            n_cmp++;
            if (got_t[i] - got_t[i-1] != gap) begin
                n_err++;
                $display("FAIL ramp_spacing[%0d] got %0d want %0d", i,
                         got_t[i] - got_t[i-1], gap);
            end
        end
    endtask

    task automatic test_wrap();
        sel = 2;
        do_reset();
        drive(1'b1, 16'd32760);
        drive(1'b1, 16'hFFFF - 16'd32765);
        idle(4);
        n_cmp++;
        if (got_d.size() != 2) begin
            n_err++;
            $display("FAIL wrap_count got %0d want 2", got_d.size());
        end else begin
            n_cmp++;
            if (got_d[0] !== 16'd32760) begin
                n_err++;
                $display("FAIL wrap_first got %0d want 32760", $signed(got_d[0]));
            end
            n_cmp++;
            if (got_d[1] !== 16'd10) begin
                n_err++;
                $display("FAIL wrap_second got %0d want 10", $signed(got_d[1]));
            end
        end
    endtask

    task automatic test_delay2();
        logic [15:0] ref_q[3];
        ref_q = '{16'd5, 16'd9, 16'd15};
        sel = 3;
        do_reset();
        drive(1'b1, 16'd5);
        drive(1'b0, 16'($urandom));
        drive(1'b1, 16'd9);
        drive(1'b1, 16'd20);
        idle(4);
        n_cmp++;
        if (got_d.size() != 3) begin
            n_err++;
            $display("FAIL m2_count got %0d want 3", got_d.size());
        end
        for (int i = 0; i < got_d.size() && i < 3; i++) begin
            n_cmp++;
            if (got_d[i] !== ref_q[i]) begin
                n_err++;
                $display("FAIL m2_data[%0d] got %0d want %0d", i, got_d[i], ref_q[i]);
            end
        end
    endtask

    task automatic test_trunc();
        logic [15:0] e;
        sel = 4;
        do_reset();
        drive(1'b1, 16'h1234);
        drive(1'b1, 16'h1634);
        for (int n = 0; n < 6; n++) drive(1'b1, 16'($urandom));
        idle(4);
        model(1, 1, 1);
        n_cmp++;
        if (got_d.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL trunc_count got %0d want %0d", got_d.size(), exp_q.size());
        end
        for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
            e = {8'h00, exp_q[i][15:8]};
            if (i == 0) e = 16'h0012;
            if (i == 1) e = 16'h0004;
            n_cmp++;
            if (got_d[i] !== e) begin
                n_err++;
                $display("FAIL trunc_data[%0d] got %h want %h", i, got_d[i], e);
            end
        end
    endtask

    task automatic test_reset_mid();
        sel = 0;
        do_reset();
        for (int n = 0; n < 6; n++) drive(1'b1, 16'd100);
        @(posedge clk);
        #1;
        reset = 1'b1;
        iv[0] = 1'b1;
        id[0] = 16'd100;
        @(posedge clk);
        #1;
        reset = 1'b0;
        iv[0] = 1'b0;
        stim_q = {};
        in_t = {};
        for (int n = 0; n < 12; n++) drive(1'b1, 16'd100);
        idle(8);
        model(3, 4, 1);
        n_cmp++;
        if (got_d.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL rmid_count got %0d want %0d", got_d.size(), exp_q.size());
        end
        if (got_t.size() > 0) begin
            n_cmp++;
            if (got_t[0] != in_t[3] + 4) begin
                n_err++;
                $display("FAIL rmid_first_time got %0d want %0d", got_t[0], in_t[3] + 4);
            end
        end
        for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL rmid_data[%0d] got %0d want %0d", i,
                         $signed(got_d[i]), $signed(exp_q[i]));
            end
        end
    endtask

    task automatic test_random(input int s, input int n_st, input int dec, input int cycles);
        sel = s;
        do_reset();
        for (int n = 0; n < cycles; n++)
            drive($urandom_range(0, 3) != 0, 16'($urandom));
        idle(10);
        model(n_st, dec, 1);
        n_cmp++;
        if (got_d.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL rand%0d_count got %0d want %0d", s, got_d.size(), exp_q.size());
        end
        for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL rand%0d_data[%0d] got %h want %h", s, i, got_d[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        sel = 2;
        do_reset();
        for (int n = 0; n < 20; n++) drive(1'b1, 16'($urandom));
        idle(4);
        model(1, 1, 1);
        n_cmp++;
        if (got_d.size() != 20) begin
            n_err++;
            $display("FAIL b2b_count got %0d want 20", got_d.size());
        end
        if (got_t.size() > 0) begin
            n_cmp++;
            if (got_t[0] != in_t[0] + 2) begin
                n_err++;
                $display("FAIL b2b_latency got %0d want %0d", got_t[0], in_t[0] + 2);
            end
        end
        for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL b2b_data[%0d] got %h want %h", i, got_d[i], exp_q[i]);
            end
            if (i > 0) begin
                n_cmp++;
                if (got_t[i] - got_t[i-1] != 1) begin
                    n_err++;
                    $display("FAIL b2b_spacing[%0d] got %0d want 1", i, got_t[i] - got_t[i-1]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            iv[i] = 1'b0;
            id[i] = 16'h0000;
        end
        test_reset();
        test_constant();
        test_ramp(1'b0);
        test_ramp(1'b1);
        test_wrap();
        test_delay2();
        test_trunc();
        test_reset_mid();
        test_random(0, 3, 4, 300);
        test_random(1, 3, 8, 400);
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
